// File: rtl/jingle_player_if.sv
// Sample-memory read port and PCM stream handshake shared by the jingle player and its neighbours.
interface jingle_player_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output mem_address,
    output mem_clken,
    input  mem_readdata,
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  mem_address,
    input  mem_clken,
    output mem_readdata,
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/jingle_player.sv
// Plays a stored PCM jingle from a 1-cycle-latency sample memory onto a valid/ready stream.
// Optional JINGLE_PLAYER_LOOP_EN adds a loop input that restarts playback after the final sample.
//
// state     | meaning
// S_IDLE    | waiting for start; outputs quiet
// S_FETCH   | address issued to sample memory with clock enable
// S_CAPTURE | memory word registered into sample_data
// S_PRESENT | sample offered downstream until accepted
module jingle_player #(
  parameter int DEPTH  = 15168,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] length,
`ifdef JINGLE_PLAYER_LOOP_EN
  input  logic              loop,
`endif
  output logic              busy,
  output logic              done,
  jingle_player_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_PRESENT
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_index, w_index_nxt;
  logic [ADDR_W-1:0] r_length, w_length_nxt;
  logic [DATA_W-1:0] r_sample, w_sample_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_done, w_done_nxt;
  logic [ADDR_W-1:0] w_length_clamped;
  logic              w_xfer;
  logic              w_last;
  logic              w_loop;

`ifdef JINGLE_PLAYER_LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = 1'b0;
`endif

  // Clamping keeps the index inside the populated part of the memory.
  assign w_length_clamped = ({1'b0, length} > DEPTH_X) ? DEPTH_X[ADDR_W-1:0] : length;
  assign w_xfer           = r_valid && bus.sample_ready;
  assign w_last           = (r_index == (r_length - IDX_ONE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_index  <= '0;
      r_length <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_index  <= w_index_nxt;
      r_length <= w_length_nxt;
      r_sample <= w_sample_nxt;
      r_valid  <= w_valid_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_index_nxt  = r_index;
    w_length_nxt = r_length;
    w_sample_nxt = r_sample;
    w_valid_nxt  = r_valid;
    w_done_nxt   = 1'b0;

    if ((r_state != S_IDLE) && stop) begin
      // A transfer coinciding with stop has already happened on the bus; just end here.
      w_state_nxt = S_IDLE;
      w_valid_nxt = 1'b0;
      w_done_nxt  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            w_length_nxt = w_length_clamped;
            w_index_nxt  = '0;
            if (w_length_clamped != '0) begin
              w_state_nxt = S_FETCH;
            end else begin
              w_done_nxt = 1'b1;
            end
          end
        end
        S_FETCH: begin
          w_state_nxt = S_CAPTURE;
        end
        S_CAPTURE: begin
          w_sample_nxt = bus.mem_readdata;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = S_PRESENT;
        end
        S_PRESENT: begin
          if (w_xfer) begin
            w_valid_nxt = 1'b0;
            if (!w_last) begin
              w_index_nxt = r_index + IDX_ONE;
              w_state_nxt = S_FETCH;
            end else if (w_loop) begin
              w_index_nxt = '0;
              w_state_nxt = S_FETCH;
            end else begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_clken    = (r_state == S_FETCH);
  assign bus.mem_address  = (r_state == S_FETCH) ? r_index : '0;
  assign bus.sample_data  = r_sample;
  assign bus.sample_valid = r_valid;
  assign busy             = (r_state != S_IDLE);
  assign done             = r_done;

endmodule

// File: tb/tb_jingle_player.sv
// Directed bench for jingle_player with a behavioural 1-cycle-latency sample memory.
module tb_jingle_player;
  localparam int DEPTH  = 15168;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [ADDR_W-1:0] length = '0;
  logic              busy;
  logic              done;
`ifdef JINGLE_PLAYER_LOOP_EN
  logic              loop = 1'b0;
`endif

  jingle_player_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  jingle_player #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .stop    (stop),
    .length  (length),
`ifdef JINGLE_PLAYER_LOOP_EN
    .loop    (loop),
`endif
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [DEPTH];

  always @(posedge clk)
    if (bus.mem_clken) bus.mem_readdata <= mem[bus.mem_address];

  // Monitor at the falling edge: sees exactly what the DUT will sample on the next rising edge.
  int                cyc = 0;
  logic [DATA_W-1:0] xq[$];
  int                xc[$];
  int                done_cnt = 0;
  int                clken_cnt = 0;
  int                valid_cnt = 0;
  logic [ADDR_W-1:0] last_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.sample_valid && bus.sample_ready) begin
      xq.push_back(bus.sample_data);
      xc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (bus.mem_clken) begin
      clken_cnt++;
      last_addr = bus.mem_address;
    end
    if (bus.sample_valid) valid_cnt++;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < lim) begin
      step();
      i++;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] len);
    length = len;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  initial begin
    bit ok;
    int xb, d0, c0, v0, i;

    for (int k = 0; k < DEPTH; k++) mem[k] = 16'(k * 37 + 16'h0F00);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    mem[3] = 16'h4444;
    bus.sample_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_valid", bus.sample_valid, 0);
    chk("rst_clken", bus.mem_clken, 0);
    chk("rst_addr",  bus.mem_address, 0);
    chk("rst_data",  bus.sample_data, 0);
    reset_n = 1'b1;
    step();

    // Test A: four back-to-back samples
    bus.sample_ready = 1'b1;
    xb = xq.size(); d0 = done_cnt;
    pulse_start(14'd4);
    chk("A_busy_after_start", busy, 1);
    chk("A_clken_first", bus.mem_clken, 1);
    wait_done(40, ok);
    chk("A_done_seen", ok, 1);
    step();
    chk("A_count", xq.size() - xb, 4);
    chk("A_d0", xq[xb+0], 16'h1111);
    chk("A_d1", xq[xb+1], 16'h2222);
    chk("A_d2", xq[xb+2], 16'h3333);
    chk("A_d3", xq[xb+3], 16'h4444);
    for (int k = 0; k < 3; k++) chk("A_spacing", xc[xb+k+1] - xc[xb+k], 3);
    chk("A_done_once", done_cnt - d0, 1);
    chk("A_busy_end", busy, 0);

    // Test B: downstream stalls for 10 cycles on the first sample
    bus.sample_ready = 1'b0;
    xb = xq.size(); c0 = clken_cnt;
    pulse_start(14'd2);
    i = 0;
    while (bus.sample_valid !== 1'b1 && i < 10) begin step(); i++; end
    chk("B_valid_seen", bus.sample_valid, 1);
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.sample_data !== 16'h1111 || bus.sample_valid !== 1'b1) ok = 1'b0;
    end
    chk("B_held_stable", ok, 1);
    chk("B_one_fetch_while_stalled", clken_cnt - c0, 1);
    bus.sample_ready = 1'b1;
    wait_done(20, ok);
    chk("B_done_seen", ok, 1);
    chk("B_count", xq.size() - xb, 2);
    chk("B_d0", xq[xb+0], 16'h1111);
    chk("B_d1", xq[xb+1], 16'h2222);
    chk("B_fetches", clken_cnt - c0, 2);

    // Test C: zero length
    step();
    c0 = clken_cnt; v0 = valid_cnt;
    length = '0;
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk("C_done_next", done, 1);
    chk("C_busy", busy, 0);
    step();
    chk("C_done_one_cycle", done, 0);
    step();
    chk("C_no_clken", clken_cnt - c0, 0);
    chk("C_no_valid", valid_cnt - v0, 0);

    // stop together with start in IDLE
    c0 = clken_cnt; d0 = done_cnt;
    length = 14'd4;
    start  = 1'b1;
    stop   = 1'b1;
    step();
    start  = 1'b0;
    stop   = 1'b0;
    chk("SS_busy", busy, 0);
    step();
    step();
    chk("SS_no_clken", clken_cnt - c0, 0);
    chk("SS_no_done", done_cnt - d0, 0);

    // Test D: oversized length clamps to DEPTH
    xb = xq.size(); d0 = done_cnt;
    pulse_start(14'd16383);
    pulse_start(14'd0);
    wait_done(46000, ok);
    chk("D_done_seen", ok, 1);
    chk("D_count", xq.size() - xb, DEPTH);
    chk("D_last_addr", last_addr, DEPTH - 1);
    chk("D_last_data", xq[xq.size()-1], mem[DEPTH-1]);
    step();
    chk("D_done_once", done_cnt - d0, 1);
    chk("D_busy_end", busy, 0);

    // Test E: stop coinciding with the transfer of sample 5; start mid-play is ignored
    xb = xq.size(); d0 = done_cnt;
    pulse_start(14'd10);
    step();
    step();
    step();
    pulse_start(14'd2);
    i = 0;
    while (!(bus.sample_valid === 1'b1 && bus.sample_data === mem[5]) && i < 40) begin
      step();
      i++;
    end
    chk("E_reached_idx5", bus.sample_data, mem[5]);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("E_valid_cleared", bus.sample_valid, 0);
    chk("E_done", done, 1);
    chk("E_busy", busy, 0);
    c0 = clken_cnt;
    step();
    step();
    step();
    step();
    chk("E_count", xq.size() - xb, 6);
    for (int k = 0; k < 6; k++) chk("E_data", xq[xb+k], mem[k]);
    chk("E_no_more_fetch", clken_cnt - c0, 0);
    chk("E_done_once", done_cnt - d0, 1);

`ifdef JINGLE_PLAYER_LOOP_EN
    // Test F: looping playback
    loop = 1'b1;
    xb = xq.size(); d0 = done_cnt;
    pulse_start(14'd3);
    i = 0;
    while ((xq.size() - xb) < 6 && i < 40) begin step(); i++; end
    chk("F_count", xq.size() - xb, 6);
    chk("F_d0", xq[xb+0], 16'h1111);
    chk("F_d1", xq[xb+1], 16'h2222);
    chk("F_d2", xq[xb+2], 16'h3333);
    chk("F_d3", xq[xb+3], 16'h1111);
    chk("F_d4", xq[xb+4], 16'h2222);
    chk("F_d5", xq[xb+5], 16'h3333);
    chk("F_no_done", done_cnt - d0, 0);
    chk("F_still_busy", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("F_done_on_stop", done, 1);
    chk("F_idle_on_stop", busy, 0);
    step();
`endif

    // Reset mid-stream aborts without done
    pulse_start(14'd10);
    for (int k = 0; k < 7; k++) step();
    chk("R_busy_before", busy, 1);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    chk("R_busy",  busy, 0);
    chk("R_done",  done, 0);
    chk("R_valid", bus.sample_valid, 0);
    chk("R_clken", bus.mem_clken, 0);
    chk("R_addr",  bus.mem_address, 0);
    chk("R_data",  bus.sample_data, 0);
    step();
    reset_n = 1'b1;
    step();
    step();
    step();
    chk("R_no_done", done_cnt - d0, 0);
    chk("R_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
